// File: rtl/branch_predictor.sv
// ID-stage branch predictor: a table of 2-bit saturating counters indexed by pc[IDX_W+1:2],
// trained from EX. Optional performance counters are enabled with `define BRANCH_PREDICTOR_PERF_EN.
module branch_predictor #(
  parameter int         IDX_W      = 4,
  parameter logic [1:0] INIT_STATE = 2'b11
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        id_branch_i,
  input  logic [31:0] id_pc_i,
  input  logic [31:0] id_imm_i,
  output logic        predict_o,
  output logic [31:0] T_pc_o,
  output logic [31:0] NT_pc_o,
  input  logic        ex_branch_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_taken_i,
  input  logic        ex_predict_i,
  input  logic [31:0] ex_T_pc_i,
  input  logic [31:0] ex_NT_pc_i,
  output logic        flush_o,
  output logic [31:0] redirect_pc_o
`ifdef BRANCH_PREDICTOR_PERF_EN
  ,
  output logic [31:0] perf_branch_o,
  output logic [31:0] perf_mispredict_o
`endif
);

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam int ENTRIES = 2 ** IDX_W;

  ctr_e             cnt_q [ENTRIES];
  ctr_e             cnt_next;
  ctr_e             id_ctr;
  logic [IDX_W-1:0] id_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             unused_ex_pc_bits;

  assign id_idx            = id_pc_i[IDX_W+1:2];
  assign ex_idx            = ex_pc_i[IDX_W+1:2];
  assign id_ctr            = cnt_q[id_idx];
  assign unused_ex_pc_bits = ^{ex_pc_i[31:IDX_W+2], ex_pc_i[1:0]};

  // Only the entry selected by the EX branch is written; ID reads see the pre-update value.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= ctr_e'(INIT_STATE);
      end
    end else if (ex_branch_i) begin
      cnt_q[ex_idx] <= cnt_next;
    end
  end

  always_comb begin
    cnt_next = cnt_q[ex_idx];
    case (cnt_q[ex_idx])
      SNT:     cnt_next = ex_taken_i ? WNT : SNT;
      WNT:     cnt_next = ex_taken_i ? WT  : SNT;
      WT:      cnt_next = ex_taken_i ? ST  : WNT;
      ST:      cnt_next = ex_taken_i ? ST  : WT;
      default: cnt_next = cnt_q[ex_idx];
    endcase
  end

  always_comb begin
    predict_o     = id_branch_i & id_ctr[1];
    T_pc_o        = id_pc_i + id_imm_i;
    NT_pc_o       = id_pc_i + 32'd4;
    flush_o       = ex_branch_i & (ex_taken_i ^ ex_predict_i);
    redirect_pc_o = '0;
    if (flush_o) begin
      redirect_pc_o = ex_taken_i ? ex_T_pc_i : ex_NT_pc_i;
    end
  end

`ifdef BRANCH_PREDICTOR_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_branch_o     <= '0;
      perf_mispredict_o <= '0;
    end else begin
      if (ex_branch_i) perf_branch_o     <= perf_branch_o + 32'd1;
      if (flush_o)     perf_mispredict_o <= perf_mispredict_o + 32'd1;
    end
  end
`endif

endmodule
